// File: rtl/seq_calc_w.sv
// Sequential two-operand calculator: serial A/B capture, one-cycle EXEC,
// registered result with a valid pulse and optional accumulator chaining.
module seq_calc_w #(
  parameter int WIDTH = 4,
  parameter int CHAIN = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic [2:0]       op,
  input  logic             capture,
  input  logic             clear,
  output logic [WIDTH:0]   result,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT_B, EXEC, CHAINED} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_MAX = 3'd5, OP_MIN = 3'd6, OP_PASS = 3'd7;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH:0]   res_nxt, alu_res, a_x, b_x;
  logic             ovf_nxt, alu_ovf;
  // vld_pipe[0] marks the EXEC stage, vld_pipe[1] is the registered pulse
  logic [1:0]       vld_pipe;

  assign a_x         = {1'b0, a_q};
  assign b_x         = {1'b0, b_q};
  assign vld_pipe[0] = (state == EXEC);
  assign busy        = vld_pipe[0];
  assign valid       = vld_pipe[1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = a_x + b_x; alu_ovf = alu_res[WIDTH]; end
      OP_SUB:  begin alu_res = a_x - b_x; alu_ovf = (a_q < b_q);    end
      OP_AND:  alu_res = a_x & b_x;
      OP_OR:   alu_res = a_x | b_x;
      OP_XOR:  alu_res = a_x ^ b_x;
      OP_MAX:  alu_res = (a_q > b_q) ? a_x : b_x;
      OP_MIN:  alu_res = (a_q < b_q) ? a_x : b_x;
      OP_PASS: alu_res = b_x;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    res_nxt   = result;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = IDLE;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
      res_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: if (capture) begin
          a_nxt     = d_in;
          state_nxt = WAIT_B;
        end
        WAIT_B, CHAINED: if (capture) begin
          b_nxt     = d_in;
          op_nxt    = op;
          state_nxt = EXEC;
        end
        EXEC: begin
          res_nxt = alu_res;
          ovf_nxt = alu_ovf;
          if (CHAIN != 0) begin
            a_nxt     = alu_res[WIDTH-1:0];
            state_nxt = CHAINED;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result      <= '0;
      ovf         <= 1'b0;
      vld_pipe[1] <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      op_q        <= op_nxt;
      result      <= res_nxt;
      ovf         <= ovf_nxt;
      vld_pipe[1] <= vld_pipe[0] & ~clear;
    end
  end

endmodule

// File: tb/tb_seq_calc_w.sv
// Bench for seq_calc_w: three instances (4-bit plain, 4-bit chained, 8-bit
// plain) share one stimulus stream and are compared to a per-instance model.
module tb_seq_calc_w;

  logic       clock = 1'b0;
  logic       rst_n, capture, clear;
  logic [7:0] d8;
  logic [2:0] op;
  logic [4:0] r0, r1;
  logic [8:0] r2;
  logic       v0, v1, v2, o0, o1, o2, b0, b1, b2;

  always #5 clock = ~clock;

  seq_calc_w #(.WIDTH(4), .CHAIN(0)) u_w4_plain (
    .clock(clock), .rst_n(rst_n), .d_in(d8[3:0]), .op(op), .capture(capture),
    .clear(clear), .result(r0), .valid(v0), .ovf(o0), .busy(b0));
  seq_calc_w #(.WIDTH(4), .CHAIN(1)) u_w4_chain (
    .clock(clock), .rst_n(rst_n), .d_in(d8[3:0]), .op(op), .capture(capture),
    .clear(clear), .result(r1), .valid(v1), .ovf(o1), .busy(b1));
  seq_calc_w #(.WIDTH(8), .CHAIN(0)) u_w8_plain (
    .clock(clock), .rst_n(rst_n), .d_in(d8), .op(op), .capture(capture),
    .clear(clear), .result(r2), .valid(v2), .ovf(o2), .busy(b2));

  int n_chk = 0, n_fail = 0, vcnt1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 wants A, 1 wants B, 2 computing, 3 holds chained A
  int wd[3]  = '{4, 4, 8};
  int chn[3] = '{0, 1, 0};
  int ph[3], ma[3], mb[3], mop[3], mres[3], movf[3], mvld[3];

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; ma[i] = 0; mb[i] = 0; mop[i] = 0; mres[i] = 0; movf[i] = 0; mvld[i] = 0;
    end
  endtask

  task automatic m_calc(input int i);
    int a, b, m;
    a = ma[i]; b = mb[i]; m = 1 << (wd[i] + 1);
    movf[i] = 0;
    case (mop[i])
      0: begin mres[i] = a + b; movf[i] = (a + b >= (1 << wd[i])) ? 1 : 0; end
      1: begin mres[i] = (a - b + m) % m; movf[i] = (a < b) ? 1 : 0; end
      2: mres[i] = a & b;
      3: mres[i] = a | b;
      4: mres[i] = a ^ b;
      5: mres[i] = (a > b) ? a : b;
      6: mres[i] = (a < b) ? a : b;
      default: mres[i] = b;
    endcase
  endtask

  task automatic m_step();
    int d;
    for (int i = 0; i < 3; i++) begin
      d = int'(d8) % (1 << wd[i]);
      if (!rst_n) begin
        ph[i] = 0; ma[i] = 0; mb[i] = 0; mres[i] = 0; movf[i] = 0; mvld[i] = 0;
      end else if (clear) begin
        ph[i] = 0; ma[i] = 0; mb[i] = 0; mres[i] = 0; movf[i] = 0; mvld[i] = 0;
      end else begin
        mvld[i] = 0;
        case (ph[i])
          0: if (capture) begin ma[i] = d; ph[i] = 1; end
          1, 3: if (capture) begin mb[i] = d; mop[i] = int'(op); ph[i] = 2; end
          default: begin
            m_calc(i);
            mvld[i] = 1;
            if (chn[i] != 0) begin ma[i] = mres[i] % (1 << wd[i]); ph[i] = 3; end
            else ph[i] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] rs[3], vs[3], os[3], bs[3];
    rs[0] = 32'(r0); rs[1] = 32'(r1); rs[2] = 32'(r2);
    vs[0] = 32'(v0); vs[1] = 32'(v1); vs[2] = 32'(v2);
    os[0] = 32'(o0); os[1] = 32'(o1); os[2] = 32'(o2);
    bs[0] = 32'(b0); bs[1] = 32'(b1); bs[2] = 32'(b2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("result[%0d]", i), rs[i], 32'(mres[i]));
      chk($sformatf("valid[%0d]", i),  vs[i], 32'(mvld[i]));
      chk($sformatf("ovf[%0d]", i),    os[i], 32'(movf[i]));
      chk($sformatf("busy[%0d]", i),   bs[i], (ph[i] == 2) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    m_step();
    @(negedge clock);
    check_all();
    if (v1 === 1'b1) vcnt1++;
  endtask

  task automatic drv(input bit cap, input int d, input int o, input bit clr);
    capture = cap; d8 = 8'(d); op = 3'(o); clear = clr;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b0; clear = 1'b0; d8 = '0; op = '0;
    m_reset();
    #3 check_all();
    @(negedge clock) rst_n = 1'b1;

    // 9 + 8 on 4 bits carries into result[4]
    drv(1, 9, 0, 0); drv(1, 8, 0, 0); drv(0, 0, 0, 0);
    chk("add9_8_res", 32'(r0), 17); chk("add9_8_ovf", 32'(o0), 1); chk("add9_8_vld", 32'(v0), 1);
    drv(0, 0, 0, 0);
    chk("add9_8_vld_drop", 32'(v0), 0); chk("add9_8_hold", 32'(r0), 17);

    drv(1, 3, 0, 0); drv(1, 5, 1, 0); drv(0, 0, 0, 0);
    chk("sub3_5_res", 32'(r0), 30); chk("sub3_5_ovf", 32'(o0), 1);
    drv(1, 5, 0, 0); drv(1, 3, 1, 0); drv(0, 0, 0, 0);
    chk("sub5_3_res", 32'(r0), 2); chk("sub5_3_ovf", 32'(o0), 0);
    drv(1, 6, 0, 0); drv(1, 10, 5, 0); drv(0, 0, 0, 0);
    chk("max_res", 32'(r0), 10);
    drv(1, 6, 0, 0); drv(1, 10, 6, 0); drv(0, 0, 0, 0);
    chk("min_res", 32'(r0), 6);

    // chained accumulation, with a capture in the EXEC cycle that must be dropped
    drv(0, 0, 0, 1);
    vcnt1 = 0;
    drv(1, 2, 0, 0); drv(1, 3, 0, 0); drv(1, 7, 0, 0);
    chk("chain_5", 32'(r1), 5);
    drv(1, 4, 0, 0); drv(0, 0, 0, 0);
    chk("chain_9", 32'(r1), 9);
    drv(1, 1, 1, 0); drv(0, 0, 0, 0);
    chk("chain_8", 32'(r1), 8);
    drv(0, 0, 0, 0);
    chk("chain_pulses", 32'(vcnt1), 3);

    // clear wins over capture; the next capture is a fresh A
    drv(1, 5, 0, 1);
    chk("clr_res", 32'(r1), 0); chk("clr_busy", 32'(b1), 0);
    drv(1, 6, 0, 0); drv(1, 2, 0, 0); drv(0, 0, 0, 0);
    chk("post_clr_res", 32'(r1), 8);

    // async reset while A is held
    drv(1, 3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("rst_async_res", 32'(r0), 0);
    @(negedge clock) rst_n = 1'b1;
    drv(1, 7, 0, 0); drv(1, 4, 0, 0); drv(0, 0, 0, 0);
    chk("post_rst_res", 32'(r0), 11);

    // 8-bit instance boundaries
    drv(0, 0, 0, 1);
    drv(1, 200, 0, 0); drv(1, 100, 0, 0); drv(0, 0, 0, 0);
    chk("w8_add_res", 32'(r2), 300); chk("w8_add_ovf", 32'(o2), 1);
    drv(1, 'hF0, 0, 0); drv(1, 'h3C, 4, 0); drv(0, 0, 0, 0);
    chk("w8_xor_res", 32'(r2), 'hCC); chk("w8_xor_ovf", 32'(o2), 0);

    for (int n = 0; n < 600; n++)
      drv($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
          int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
